ram16k_arbiter: RTL

- Shares one ram16k instance between two requesters, A (CPU data port) and B (DMA/screen engine), using req/ack handshakes and round-robin arbitration.
- After reset it can sweep all 16384 words to zero before accepting requests.
- Sits between the CPU/peripheral fabric and ram16k. It owns the ram16k `load` and `address` inputs exclusively.

---
 rtl/ram16k_arbiter_pkg.sv | 7 +
 rtl/ram16k.sv | 13 +
 rtl/rr_arb2.sv | 10 +
 rtl/ram16k_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/ram16k_arbiter_pkg.sv
// ram16k_arbiter_pkg: shared state and requester encodings for the ram16k arbiter
package ram16k_arbiter_pkg;
  typedef enum logic [1:0] {CLEAR = 2'd0, IDLE = 2'd1, ACCESS = 2'd2, DONE = 2'd3} state_e;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;
  localparam int AW = 14;
  localparam int DW = 16;
endpackage

// File: rtl/ram16k.sv
// ram16k: 16K x 16 word memory, combinational read, write on clock edge when load is high
module ram16k (
  input  logic        clk,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [13:0] address,
  output logic [15:0] out
);
  logic [15:0] mem_q [16384];
  always_ff @(posedge clk)
    if (load) mem_q[address] <= in;
  assign out = mem_q[address];
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; the pointer only breaks ties
module rr_arb2 import ram16k_arbiter_pkg::*; (
  input  logic [1:0] req_i,
  input  req_id_e    ptr_i,
  output logic       gnt_vld_o,
  output req_id_e    gnt_id_o
);
  assign gnt_vld_o = |req_i;
  assign gnt_id_o  = &req_i ? ptr_i : req_id_e'(req_i[1]);
endmodule

// File: rtl/ram16k_arbiter.sv
// ram16k_arbiter: shares one ram16k between requesters A and B with req/ack handshakes,
// round-robin arbitration and an optional zero-fill sweep after reset.
module ram16k_arbiter import ram16k_arbiter_pkg::*; #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          busy
);
  state_e        state_q, state_d;
  req_id_e       ptr_q, ptr_d, id_q, id_d, gnt_id;
  logic          gnt_vld, we_q, we_d, ram_load;
  logic [AW-1:0] clr_addr_q, clr_addr_d, addr_q, addr_d, ram_addr;
  logic [DW-1:0] wdata_q, wdata_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d, ram_in, ram_out;
  rr_arb2 u_arb (
    .req_i    ({b_req, a_req}),
    .ptr_i    (ptr_q),
    .gnt_vld_o(gnt_vld),
    .gnt_id_o (gnt_id)
  );
  ram16k u_ram (
    .clk    (clk),
    .in     (ram_in),
    .load   (ram_load),
    .address(ram_addr),
    .out    (ram_out)
  );
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        state_d    = &clr_addr_q ? IDLE : CLEAR;
      end
      IDLE: if (gnt_vld) begin
        id_d    = gnt_id;
        we_d    = gnt_id == REQ_B ? b_we : a_we;
        addr_d  = gnt_id == REQ_B ? b_addr : a_addr;
        wdata_d = gnt_id == REQ_B ? b_wdata : a_wdata;
        state_d = ACCESS;
      end
      ACCESS: begin
        a_rdata_d = id_q == REQ_A ? ram_out : a_rdata_q;
        b_rdata_d = id_q == REQ_B ? ram_out : b_rdata_q;
        ptr_d     = id_q == REQ_A ? REQ_B : REQ_A;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // load is gated by reset so an aborted CLEAR or ACCESS never writes on the reset edge
  assign ram_addr = state_q == CLEAR ? clr_addr_q : addr_q;
  assign ram_in   = state_q == CLEAR ? '0 : wdata_q;
  assign ram_load = !reset && (state_q == CLEAR || (state_q == ACCESS && we_q));
  assign a_ack    = state_q == DONE && id_q == REQ_A;
  assign b_ack    = state_q == DONE && id_q == REQ_B;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign busy     = state_q != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_addr_q <= '0;
      ptr_q      <= REQ_A;
      id_q       <= REQ_A;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end
endmodule
